branch_seq_unit: RTL and testbench
==================================

// Module: branch_seq_unit
// PURPOSE
//  Parametrised PC sequencer for the next-generation datapath. Owns the PC, the registered ALU flags and
//  run-time writable relative/absolute branch-target tables, which replace the fixed LUT_16 constants.
//  Adds a call/return-address stack, a stall input and a halt/DONE state machine.
//  Sits between the controller (branch/call/ret strobes) and InstROM (PC).
// PARAMETERS
//  PC_W       16  PC and table-entry width
//  TBL_DEPTH  32  entries per target table (power of 2); IDX_W = $clog2(TBL_DEPTH)
//  RAS_DEPTH  4   return-address stack entries (>=2)
// PORTS
//  CLK          in   1      clock; all state updates on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      sync re-init: PC=0, flags/RAS/errors cleared, enter RUN
//  halt         in   1      end of program; RUN->DONE
//  stall        in   1      hold PC, RAS and state this cycle
//  br_abs       in   1      PC <= abs_tbl[idx]
//  br_rel_z     in   1      if F_ZERO: PC <= PC + rel_tbl[idx]
//  br_rel_nz    in   1      if !F_ZERO: PC <= PC + rel_tbl[idx]
//  call         in   1      push PC+1; PC <= abs_tbl[idx]
//  ret          in   1      PC <= pop
//  idx          in   IDX_W  table index for the current instruction
//  flag_we      in   1      load alu_zero/alu_c/alu_s into flag registers
//  alu_zero, alu_c, alu_s  in  1 each   ALU flag outputs
//  tbl_we       in   1      table write strobe
//  tbl_sel      in   1      0 = rel table, 1 = abs table
//  tbl_waddr    in   IDX_W  write index
//  tbl_wdata    in   PC_W   write data (rel entries are two's complement)
//  PC           out  PC_W   current instruction address
//  F_ZERO, F_C_OUT, F_S_OUT  out  1 each   registered flags
//  DONE         out  1      high while in DONE state
//  ras_err      out  1      sticky: overflow or underflow occurred since start
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, PC=0, flags=0, DONE=0, ras_err=0, RAS empty, all table entries 0.
//  States:
//   - IDLE: PC held; strobes ignored. start -> RUN.
//   - RUN: halt -> DONE.
//   - DONE: PC held. start -> RUN.
//   start takes priority over everything, in every state.
//  RUN, stall=0: one next-PC action per cycle, priority ret > call > br_abs > br_rel_z/nz > PC+1.
//   br_rel_z and br_rel_nz together => taken iff the selected condition holds.
//   Untaken relative branch => PC+1.
//  halt with other strobes in the same cycle: PC still updates that cycle, then DONE.
//  Arithmetic: PC + rel_tbl[idx] and PC+1 computed mod 2^PC_W (wrap, no error).
//   The relative offset is a full PC_W-bit signed value.
//  Branch conditions use the registered F_ZERO (flags written by the previous instruction).
//   Same-cycle flag_we does not affect the branch.
//  flag_we updates the flags in RUN only, including during stall. start clears the flags.
//  stall=1: PC, RAS, ras_err and state are held; halt is ignored; table writes still occur.
//  Tables: tbl_we writes in any state; 1-cycle latency.
//   A read of the entry being written in the same cycle returns the old value.
//   start does NOT clear the tables; only reset_n does.
//  RAS:
//   - call when full: no push, jump still taken, ras_err<=1.
//   - ret when empty: PC<=PC+1, ras_err<=1.
//   - call and ret together: ret wins; no push.
//  Reset mid-operation: async clear as above; the state is not resumed.
// CONFIGURATION
//  BSU_RAS_EN defined: call/ret and the RAS operate as above.
//  BSU_RAS_EN undefined: no RAS storage; call behaves exactly as br_abs (no push);
//   ret is ignored (PC+1 unless another strobe applies); ras_err is tied 0.
// STRUCTURE
//  Package definitions gains:
//   - typedef enum logic [1:0] {BSU_IDLE, BSU_RUN, BSU_DONE} bsu_state_t;
//   - typedef enum {NPC_INC, NPC_REL, NPC_ABS, NPC_CALL, NPC_RET} bsu_npc_t;
//   - localparam BSU_PC_RESET = '0.
//  Sub-module bsu_ras (push/pop/full/empty, depth RAS_DEPTH), instantiated only under BSU_RAS_EN.
//  Tables, next-PC mux, flags and FSM live in the top module.
// TESTING
//  1. Reset + start, no strobes, 5 cycles -> PC 0,1,2,3,4; DONE=0.
//  2. Write rel_tbl[3]=-2, PC=10, F_ZERO=1, br_rel_z idx=3 -> PC=8.
//     Same with F_ZERO=0 -> PC=11.
//  3. Write abs_tbl[5]=0x40, call idx=5 at PC=7 -> PC=0x40; later ret -> PC=8.
//     Nested calls to depth 4 unwind in LIFO order.
//  4. Fifth nested call (RAS_DEPTH=4) -> jump taken, ras_err=1.
//     ret on empty stack -> PC+1, ras_err stays 1 until start.
//  5. stall for 3 cycles during br_abs -> PC held; branch applied on the first unstalled cycle.
//     halt -> DONE=1, PC frozen; start -> PC=0, DONE=0.
//  6. PC=0xFFFF, no strobe -> PC=0x0000.
//     Assert reset_n low mid-RUN -> PC=0 and tables=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/branch_seq_unit_pkg.sv
// ============================================================================
// Module   : branch_seq_unit_pkg
// Purpose  : Shared types and constants for the branch/PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_seq_unit_pkg;

  typedef enum logic [1:0] {BSU_IDLE, BSU_RUN, BSU_DONE} bsu_state_t;

  typedef enum {NPC_INC, NPC_REL, NPC_ABS, NPC_CALL, NPC_RET} bsu_npc_t;

  localparam BSU_PC_RESET = '0;

endpackage

`default_nettype wire

// File: rtl/bsu_ras.sv
// ============================================================================
// Module   : bsu_ras
// Purpose  : Return-address stack (LIFO) with full/empty status; built only
//            when BSU_RAS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef BSU_RAS_EN
module bsu_ras
  import branch_seq_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_top,
  output logic              o_full,
  output logic              o_empty
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_stack [DEPTH];
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_ptr_w-1:0] w_top_ptr;

  // cnt-1 never exceeds DEPTH-1, so the low pointer bits suffice
  assign w_top_ptr = r_cnt[c_ptr_w-1:0] - c_ptr_w'(1);
  assign o_top     = r_stack[w_top_ptr];
  assign o_full    = (r_cnt == c_cnt_w'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_stack[r_cnt[c_ptr_w-1:0]] <= i_data;
      r_cnt <= r_cnt + c_cnt_w'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/branch_seq_unit.sv
// ============================================================================
// Module   : branch_seq_unit
// Purpose  : PC sequencer with writable branch-target tables, registered ALU
//            flags, optional return-address stack (macro BSU_RAS_EN) and an
//            IDLE/RUN/DONE control state machine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_seq_unit
  import branch_seq_unit_pkg::*;
#(
  parameter int  PC_W      = 16,
  parameter int  TBL_DEPTH = 32,
  parameter int  RAS_DEPTH = 4,
  localparam int IDX_W     = $clog2(TBL_DEPTH)
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_abs,
  input  logic             br_rel_z,
  input  logic             br_rel_nz,
  input  logic             call,
  input  logic             ret,
  input  logic [IDX_W-1:0] idx,
  input  logic             flag_we,
  input  logic             alu_zero,
  input  logic             alu_c,
  input  logic             alu_s,
  input  logic             tbl_we,
  input  logic             tbl_sel,
  input  logic [IDX_W-1:0] tbl_waddr,
  input  logic [PC_W-1:0]  tbl_wdata,
  output logic [PC_W-1:0]  PC,
  output logic             F_ZERO,
  output logic             F_C_OUT,
  output logic             F_S_OUT,
  output logic             DONE,
  output logic             ras_err
);

  bsu_state_t       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_f_zero, r_f_c, r_f_s;
  logic             r_done, r_ras_err;
  logic [PC_W-1:0]  r_rel_tbl [TBL_DEPTH];
  logic [PC_W-1:0]  r_abs_tbl [TBL_DEPTH];

  logic [PC_W-1:0]  w_pc_inc, w_rel_tgt, w_abs_tgt, w_npc, w_ras_top;
  logic             w_rel_take, w_advance, w_ras_full, w_ras_empty, w_ras_err_set;
  bsu_npc_t         w_npc_sel;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_rel_tgt  = r_pc + r_rel_tbl[idx];
  assign w_abs_tgt  = r_abs_tbl[idx];
  // Conditions look at the flag register, never at the same-cycle ALU flags
  assign w_rel_take = (br_rel_z && r_f_zero) || (br_rel_nz && !r_f_zero);
  assign w_advance  = (r_state == BSU_RUN) && !stall && !start;

  always_comb begin
    w_npc_sel = NPC_INC;
`ifdef BSU_RAS_EN
    if (ret)             w_npc_sel = NPC_RET;
    else if (call)       w_npc_sel = NPC_CALL;
    else if (br_abs)     w_npc_sel = NPC_ABS;
    else if (w_rel_take) w_npc_sel = NPC_REL;
`else
    if (call || br_abs)  w_npc_sel = NPC_ABS;
    else if (w_rel_take) w_npc_sel = NPC_REL;
`endif
  end

  always_comb begin
    w_npc = w_pc_inc;
    case (w_npc_sel)
      NPC_REL:           w_npc = w_rel_tgt;
      NPC_ABS, NPC_CALL: w_npc = w_abs_tgt;
      NPC_RET:           w_npc = w_ras_empty ? w_pc_inc : w_ras_top;
      default:           w_npc = w_pc_inc;
    endcase
  end

`ifdef BSU_RAS_EN
  logic w_ras_push, w_ras_pop;

  assign w_ras_push    = w_advance && (w_npc_sel == NPC_CALL) && !w_ras_full;
  assign w_ras_pop     = w_advance && (w_npc_sel == NPC_RET) && !w_ras_empty;
  assign w_ras_err_set = w_advance && (((w_npc_sel == NPC_CALL) && w_ras_full) ||
                                       ((w_npc_sel == NPC_RET) && w_ras_empty));

  bsu_ras #(
    .DATA_W (PC_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .rst_n   (reset_n),
    .i_clear (start),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );
`else
  logic w_unused_ras;

  assign w_ras_top     = '0;
  assign w_ras_full    = 1'b0;
  assign w_ras_empty   = 1'b1;
  assign w_ras_err_set = 1'b0;
  assign w_unused_ras  = ret ^ (RAS_DEPTH < 2);
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= BSU_IDLE;
      r_pc      <= PC_W'(BSU_PC_RESET);
      r_f_zero  <= 1'b0;
      r_f_c     <= 1'b0;
      r_f_s     <= 1'b0;
      r_done    <= 1'b0;
      r_ras_err <= 1'b0;
    end else if (start) begin
      r_state   <= BSU_RUN;
      r_pc      <= PC_W'(BSU_PC_RESET);
      r_f_zero  <= 1'b0;
      r_f_c     <= 1'b0;
      r_f_s     <= 1'b0;
      r_done    <= 1'b0;
      r_ras_err <= 1'b0;
    end else begin
      case (r_state)
        BSU_RUN: begin
          if (flag_we) begin
            r_f_zero <= alu_zero;
            r_f_c    <= alu_c;
            r_f_s    <= alu_s;
          end
          if (!stall) begin
            r_pc <= w_npc;
            if (w_ras_err_set) r_ras_err <= 1'b1;
            if (halt) begin
              r_state <= BSU_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Table writes ignore state, stall and start; only reset_n clears them
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        r_rel_tbl[i] <= '0;
        r_abs_tbl[i] <= '0;
      end
    end else if (tbl_we) begin
      if (tbl_sel) r_abs_tbl[tbl_waddr] <= tbl_wdata;
      else         r_rel_tbl[tbl_waddr] <= tbl_wdata;
    end
  end

  assign PC      = r_pc;
  assign F_ZERO  = r_f_zero;
  assign F_C_OUT = r_f_c;
  assign F_S_OUT = r_f_s;
  assign DONE    = r_done;
  assign ras_err = r_ras_err;

endmodule

`default_nettype wire

// File: tb/tb_branch_seq_unit.sv
// ============================================================================
// Module   : tb_branch_seq_unit
// Purpose  : Scoreboard bench for branch_seq_unit; RAS checks under BSU_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_seq_unit;

  logic        CLK = 1'b0;
  logic        reset_n, start, halt, stall, br_abs, br_rel_z, br_rel_nz, call, ret;
  logic [4:0]  idx, tbl_waddr;
  logic        flag_we, alu_zero, alu_c, alu_s, tbl_we, tbl_sel;
  logic [15:0] tbl_wdata;
  logic [15:0] PC;
  logic        F_ZERO, F_C_OUT, F_S_OUT, DONE, ras_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic        dn;
    int          er;
    int          fz;
  } exp_t;

  exp_t q[$];

  branch_seq_unit dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .halt(halt), .stall(stall),
    .br_abs(br_abs), .br_rel_z(br_rel_z), .br_rel_nz(br_rel_nz), .call(call), .ret(ret),
    .idx(idx), .flag_we(flag_we), .alu_zero(alu_zero), .alu_c(alu_c), .alu_s(alu_s),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .PC(PC), .F_ZERO(F_ZERO), .F_C_OUT(F_C_OUT), .F_S_OUT(F_S_OUT), .DONE(DONE),
    .ras_err(ras_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: the DUT presents a new PC after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, " pc"}, 32'(PC), 32'(e.pc));
        check({e.nm, " done"}, 32'(DONE), 32'(e.dn));
        if (e.er >= 0) check({e.nm, " ras_err"}, 32'(ras_err), 32'(e.er));
        if (e.fz >= 0) check({e.nm, " f_zero"}, 32'(F_ZERO), 32'(e.fz));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    start = 0; halt = 0; stall = 0; br_abs = 0; br_rel_z = 0; br_rel_nz = 0;
    call = 0; ret = 0; idx = '0; flag_we = 0; alu_zero = 0; alu_c = 0; alu_s = 0;
    tbl_we = 0; tbl_sel = 0; tbl_waddr = '0; tbl_wdata = '0;
  endtask

  task automatic wr(input logic sel, input logic [4:0] a, input logic [15:0] d);
    tbl_we = 1; tbl_sel = sel; tbl_waddr = a; tbl_wdata = d;
  endtask

  // Inputs already driven; queue the expected post-edge state and advance
  task automatic step(input string nm, input logic [15:0] pc,
                      input logic dn = 1'b0, input int er = -1, input int fz = -1);
    exp_t e;
    e.nm = nm; e.pc = pc; e.dn = dn; e.er = er; e.fz = fz;
    q.push_back(e);
    @(negedge CLK);
    clr();
  endtask

  logic [15:0] hold_pc;
  int          e_err;

  initial begin
    clr();
    reset_n = 0;
    #2;
    check("rst pc", 32'(PC), 32'h0);
    check("rst done", 32'(DONE), 32'h0);
    check("rst ras_err", 32'(ras_err), 32'h0);
    check("rst f_zero", 32'(F_ZERO), 32'h0);
    @(negedge CLK);
    reset_n = 1;

    br_abs = 1;                         step("idle hold", 16'h0000);
    start = 1;                          step("start", 16'h0000, 0, 0, 0);
    step("inc1", 16'h0001); step("inc2", 16'h0002);
    step("inc3", 16'h0003); step("inc4", 16'h0004);
    wr(0, 5'd3, 16'hFFFE);              step("wr rel3", 16'h0005);
    wr(1, 5'd5, 16'h0040);              step("wr abs5", 16'h0006);
    wr(1, 5'd6, 16'h0100);              step("wr abs6", 16'h0007);
    wr(1, 5'd7, 16'h0200);              step("wr abs7", 16'h0008);
    wr(1, 5'd8, 16'h0300);              step("wr abs8", 16'h0009);
    wr(1, 5'd9, 16'h0500); flag_we = 1; alu_zero = 1;
                                        step("set zero", 16'h000A, 0, -1, 1);
    br_rel_z = 1; idx = 3; flag_we = 1; alu_zero = 0;
                                        step("relz taken", 16'h0008, 0, -1, 0);
    br_rel_z = 1; idx = 3;              step("relz untaken", 16'h0009);
    br_rel_nz = 1; idx = 3;             step("relnz taken", 16'h0007);
    br_rel_z = 1; br_rel_nz = 1; idx = 3; step("rel both", 16'h0005);
    step("inc6", 16'h0006); step("inc7", 16'h0007);
    call = 1; idx = 5;                  step("call abs5", 16'h0040, 0, 0);
    step("inc41", 16'h0041);

`ifdef BSU_RAS_EN
    ret = 1;                            step("ret to 8", 16'h0008, 0, 0);
    call = 1; idx = 6;                  step("nest1", 16'h0100);
    call = 1; idx = 7;                  step("nest2", 16'h0200);
    call = 1; idx = 8;                  step("nest3", 16'h0300);
    call = 1; idx = 9;                  step("nest4", 16'h0500, 0, 0);
    call = 1; idx = 5;                  step("call full", 16'h0040, 0, 1);
    ret = 1;                            step("unwind4", 16'h0301);
    ret = 1;                            step("unwind3", 16'h0201);
    ret = 1;                            step("unwind2", 16'h0101);
    ret = 1;                            step("unwind1", 16'h0009);
    ret = 1;                            step("ret empty", 16'h000A, 0, 1);
    call = 1; ret = 1; idx = 6;         step("call+ret", 16'h000B, 0, 1);
    step("inc c", 16'h000C);
    ret = 1;                            step("ret no push", 16'h000D, 0, 1);
    hold_pc = 16'h000D;
    e_err   = 1;
`else
    ret = 1;                            step("ret ignored", 16'h0042, 0, 0);
    call = 1; idx = 6;                  step("call as abs", 16'h0100, 0, 0);
    ret = 1;                            step("ret ignored2", 16'h0101);
    call = 1; ret = 1; idx = 7;         step("call+ret", 16'h0200, 0, 0);
    hold_pc = 16'h0200;
    e_err   = 0;
`endif

    stall = 1; br_abs = 1; idx = 9; halt = 1;
                                        step("stall1", hold_pc, 0, e_err);
    stall = 1; br_abs = 1; idx = 9; flag_we = 1; alu_zero = 1; wr(0, 5'd4, 16'h0010);
                                        step("stall2", hold_pc, 0, e_err, 1);
    stall = 1; br_abs = 1; idx = 9;     step("stall3", hold_pc, 0, e_err, 1);
    br_abs = 1; idx = 9;                step("unstall abs", 16'h0500, 0, e_err);
    br_rel_z = 1; idx = 4;              step("rel stallwr", 16'h0510, 0, -1, 1);
    halt = 1; br_abs = 1; idx = 5;      step("halt", 16'h0040, 1);
    br_abs = 1; idx = 9; flag_we = 1; alu_zero = 0;
                                        step("done hold", 16'h0040, 1, -1, 1);
    start = 1;                          step("restart", 16'h0000, 0, 0, 0);

    wr(1, 5'd10, 16'hFFFF);             step("wr abs10", 16'h0001);
    wr(0, 5'd11, 16'h0002);             step("wr rel11", 16'h0002);
    br_abs = 1; idx = 10;               step("to ffff", 16'hFFFF);
    step("wrap inc", 16'h0000);
    br_abs = 1; idx = 10;               step("to ffff2", 16'hFFFF);
    br_rel_nz = 1; idx = 11;            step("wrap rel", 16'h0001);
    step("inc before rst", 16'h0002);

    #2;
    reset_n = 0;
    #1;
    check("async rst pc", 32'(PC), 32'h0);
    check("async rst done", 32'(DONE), 32'h0);
    @(negedge CLK);
    reset_n = 1;
    br_abs = 1; idx = 10;               step("post rst idle", 16'h0000);
    start = 1;                          step("post rst start", 16'h0000);
    br_abs = 1; idx = 10; wr(1, 5'd10, 16'h0777);
                                        step("tbl cleared", 16'h0000);
    br_abs = 1; idx = 10;               step("new entry", 16'h0777);

    @(negedge CLK);
    check("queue drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
